// File: rtl/uart_frac_baud_gen_pkg.sv
// Shared constants for the UART fractional baud-tick generator.
// Holds the default parameter values, the minimum legal integer divisor and the
// width rule for the oversample counter.
package uart_frac_baud_gen_pkg;

  localparam int unsigned UART_DIV_W_DEF  = 16;
  localparam int unsigned UART_FRAC_W_DEF = 4;
  localparam int unsigned UART_OVS_DEF    = 16;

  // Smallest div_int that yields a usable period; anything below raises cfg_err.
  localparam int unsigned UART_DIV_MIN = 2;

  // Width of the oversample counter (OVS legal range 2..256).
  function automatic int unsigned ovs_width(input int unsigned ovs);
    return $clog2(ovs);
  endfunction

endpackage

// File: rtl/uart_os_counter.sv
// Modulo-OVS oversample counter with mid-bit and bit-boundary decode.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   clear       synchronous clear to 0 (idle or resync)
//   tick        os_tick condition for this cycle; advances the counter
//   os_cnt      current oversample index within the bit
//   mid_hit     tick coincides with os_cnt == OVS/2-1 (combinational)
//   bit_hit     tick coincides with os_cnt == OVS-1 (combinational)
module uart_os_counter
  import uart_frac_baud_gen_pkg::*;
#(
  parameter int unsigned OVS   = UART_OVS_DEF,
  parameter int unsigned OVS_W = ovs_width(OVS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             tick,
  output logic [OVS_W-1:0] os_cnt,
  output logic             mid_hit,
  output logic             bit_hit
);

  localparam logic [OVS_W-1:0] MidIdx  = OVS_W'(OVS / 2 - 1);
  localparam logic [OVS_W-1:0] LastIdx = OVS_W'(OVS - 1);

  logic [OVS_W-1:0] os_cnt_q, os_cnt_d;

  always_comb begin
    os_cnt_d = os_cnt_q;
    if (clear) begin
      os_cnt_d = '0;
    end else if (tick) begin
      // Explicit wrap so non-power-of-two OVS works.
      os_cnt_d = (os_cnt_q == LastIdx) ? '0 : os_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      os_cnt_q <= '0;
    end else begin
      os_cnt_q <= os_cnt_d;
    end
  end

  assign os_cnt  = os_cnt_q;
  assign mid_hit = tick && (os_cnt_q == MidIdx);
  assign bit_hit = tick && (os_cnt_q == LastIdx);

endmodule

// File: rtl/uart_frac_baud_gen.sv
// UART baud-tick generator: oversample tick plus mid-bit and bit-boundary ticks.
// Integer divider with an optional fractional accumulator, enabled by defining
// the macro UART_BAUD_GEN_FRAC_EN (without it div_frac is ignored, N = div_int).
// Ports:
//   clk, rst_n  clock / async active-low reset
//   en          enable; low holds the generator idle and reloads the divisor
//   resync      1-cycle pulse restarting bit timing from phase 0
//   div_int     integer clk cycles per oversample tick (>= 2)
//   div_frac    fractional cycles per tick, units of 1/2**FRAC_W
//   os_tick     registered pulse every oversample period
//   mid_tick    registered pulse on the os_tick with os_cnt == OVS/2-1
//   bit_tick    registered pulse on the os_tick with os_cnt == OVS-1
//   cfg_err     high while enabled with an active div_int below the minimum
module uart_frac_baud_gen
  import uart_frac_baud_gen_pkg::*;
#(
  parameter int unsigned DIV_W  = UART_DIV_W_DEF,
  parameter int unsigned FRAC_W = UART_FRAC_W_DEF,
  parameter int unsigned OVS    = UART_OVS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              resync,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              os_tick,
  output logic              mid_tick,
  output logic              bit_tick,
  output logic              cfg_err
);

  localparam int unsigned OVS_W = ovs_width(OVS);
  localparam int unsigned CNT_W = DIV_W + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period;
  logic [DIV_W-1:0] div_int_q;
  logic             os_tick_q, mid_tick_q, bit_tick_q, cfg_err_q;
  logic             carry;
  logic             clear, div_bad, tick_hit, load_div;
  logic             mid_hit, bit_hit;
  logic [OVS_W-1:0] os_cnt;

  assign clear    = !en || resync;
  assign div_bad  = div_int_q < DIV_W'(UART_DIV_MIN);
  assign period   = {1'b0, div_int_q} + CNT_W'(carry);
  // resync suppresses a tick that would otherwise land in the same cycle.
  assign tick_hit = en && !resync && !div_bad && (cnt_q == period);
  // Divisor only changes between bits so a running bit keeps its timing.
  assign load_div = clear || bit_hit;

`ifdef UART_BAUD_GEN_FRAC_EN
  logic [FRAC_W-1:0] div_frac_q, acc_q, acc_d;
  logic              carry_q, carry_d;

  always_comb begin
    acc_d   = acc_q;
    carry_d = carry_q;
    if (clear) begin
      acc_d   = '0;
      carry_d = 1'b0;
    end else if (tick_hit) begin
      // Carry stretches the following period by one cycle.
      {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, div_frac_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      carry_q    <= 1'b0;
      div_frac_q <= '0;
    end else begin
      acc_q   <= acc_d;
      carry_q <= carry_d;
      if (load_div) begin
        div_frac_q <= div_frac;
      end
    end
  end

  assign carry = carry_q;
`else
  logic unused_div_frac;
  assign unused_div_frac = ^div_frac;
  assign carry = 1'b0;
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (clear || tick_hit) begin
      cnt_d = CNT_W'(1);
    end else if (!div_bad) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= CNT_W'(1);
      div_int_q  <= '0;
      os_tick_q  <= 1'b0;
      mid_tick_q <= 1'b0;
      bit_tick_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (load_div) begin
        div_int_q <= div_int;
      end
      os_tick_q  <= tick_hit;
      mid_tick_q <= mid_hit;
      bit_tick_q <= bit_hit;
      cfg_err_q  <= en && div_bad;
    end
  end

  uart_os_counter #(
    .OVS   (OVS),
    .OVS_W (OVS_W)
  ) u_os_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .tick    (tick_hit),
    .os_cnt  (os_cnt),
    .mid_hit (mid_hit),
    .bit_hit (bit_hit)
  );

  assign os_tick  = os_tick_q;
  assign mid_tick = mid_tick_q;
  assign bit_tick = bit_tick_q;
  assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_uart_frac_baud_gen.sv
// Scoreboard bench for uart_frac_baud_gen. An event-time reference model predicts
// the edge on which each os_tick is registered and pushes it into a queue; a
// monitor on the falling edge pops and compares tick timing and mid/bit flags.
module tb_uart_frac_baud_gen;

  localparam int unsigned DIV_W  = 16;
  localparam int unsigned FRAC_W = 4;
  localparam int unsigned OVS    = 16;
`ifdef UART_BAUD_GEN_FRAC_EN
  localparam bit FracEn = 1'b1;
`else
  localparam bit FracEn = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              resync = 1'b0;
  logic [DIV_W-1:0]  div_int = '0;
  logic [FRAC_W-1:0] div_frac = '0;
  logic              os_tick, mid_tick, bit_tick, cfg_err;

  uart_frac_baud_gen #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W),
    .OVS    (OVS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .resync   (resync),
    .div_int  (div_int),
    .div_frac (div_frac),
    .os_tick  (os_tick),
    .mid_tick (mid_tick),
    .bit_tick (bit_tick),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit mid;
    bit last;
  } tick_t;

  tick_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;

  // Reference model: active divisor, tick index in bit, fractional sum, next due edge.
  int m_d = 0, m_f = 0, m_j = 0, m_fsum = 0, m_due = 0;
  bit m_cfg = 1'b0;

  int bit_gap_exp = 0;
  int last_bit_cyc = -1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge();
    tick_t t;
    int    c;
    if (!rst_n) begin
      m_d = 0; m_f = 0; m_j = 0; m_fsum = 0; m_due = 0; m_cfg = 1'b0;
      return;
    end
    m_cfg = en && (m_d < 2);
    if (!en || resync) begin
      m_d    = int'(div_int);
      m_f    = int'(div_frac);
      m_j    = 0;
      m_fsum = 0;
      m_due  = cyc + m_d;
    end else if (m_d >= 2 && cyc == m_due) begin
      t.cyc  = cyc;
      t.mid  = (m_j == OVS / 2 - 1);
      t.last = (m_j == OVS - 1);
      exp_q.push_back(t);
      c = 0;
      if (FracEn) begin
        m_fsum += m_f;
        if (m_fsum >= (1 << FRAC_W)) begin
          c = 1;
          m_fsum -= (1 << FRAC_W);
        end
      end
      m_j = (m_j + 1) % OVS;
      if (t.last) begin
        m_d = int'(div_int);
        m_f = int'(div_frac);
      end
      m_due = cyc + m_d + c;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  // Monitor / scoreboard.
  initial begin
    tick_t t;
    forever begin
      @(negedge clk);
      chk("cfg_err", 32'(cfg_err), 32'(m_cfg));
      if (os_tick) begin
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          t = exp_q.pop_front();
          chk("mid_tick", 32'(mid_tick), 32'(t.mid));
          chk("bit_tick", 32'(bit_tick), 32'(t.last));
          if (bit_tick && bit_gap_exp > 0) begin
            if (last_bit_cyc >= 0) chk("bit_period", cyc - last_bit_cyc, bit_gap_exp);
            last_bit_cyc = cyc;
          end
        end else begin
          chk("os_tick_unexpected", 32'(os_tick), 0);
        end
      end else begin
        chk("mid_tick_idle", 32'(mid_tick), 0);
        chk("bit_tick_idle", 32'(bit_tick), 0);
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          chk("os_tick_missing", 32'(os_tick), 1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, p;
    // Reset state.
    rst_n = 1'b0;
    run(3);
    chk("rst_os_tick", 32'(os_tick), 0);
    chk("rst_mid_tick", 32'(mid_tick), 0);
    chk("rst_bit_tick", 32'(bit_tick), 0);
    chk("rst_cfg_err", 32'(cfg_err), 0);
    rst_n = 1'b1;

    // Plain divide-by-4: tick every 4, bit every 64, mid at index 7.
    div_int = 16'd4; div_frac = 4'd0;
    run(1);
    en = 1'b1;
    run(140);

    // Divisor change mid-bit at os_cnt=5 takes effect only after the bit.
    for (int k = 0; k < 200 && m_j != 5; k++) cycle();
    div_int = 16'd8;
    run(200);

    // Resync at os_cnt=9 with cnt=3 on a divide-by-4 run.
    div_int = 16'd4; en = 1'b0;
    run(1);
    en = 1'b1;
    for (int k = 0; k < 300 && !(m_j == 9 && m_due - cyc == 2); k++) cycle();
    resync = 1'b1;
    cycle();
    resync = 1'b0;
    run(90);
    // Resync landing exactly on a due tick.
    for (int k = 0; k < 20 && (m_due - cyc != 1); k++) cycle();
    resync = 1'b1;
    cycle();
    resync = 1'b0;
    run(30);

    // 115200 baud x16 from 100 MHz.
    en = 1'b0; div_int = 16'd54; div_frac = 4'd4;
    run(1);
    en = 1'b1;
    last_bit_cyc = -1;
    bit_gap_exp = FracEn ? 868 : 864;
    run(3 * 870 + 60);
    bit_gap_exp = 0;

    // Illegal divisor, then legal reload via idle and via resync.
    en = 1'b0; div_int = 16'd1; div_frac = 4'd0;
    run(1);
    en = 1'b1;
    run(20);
    en = 1'b0; div_int = 16'd3;
    run(1);
    en = 1'b1;
    run(40);
    en = 1'b0; div_int = 16'd0;
    run(1);
    en = 1'b1;
    run(10);
    div_int = 16'd5; resync = 1'b1;
    cycle();
    resync = 1'b0;
    run(30);

    // Asynchronous reset mid-bit.
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    chk("async_rst_os_tick", 32'(os_tick), 0);
    chk("async_rst_cfg_err", 32'(cfg_err), 0);
    run(2);
    rst_n = 1'b1;
    div_int = 16'd5;
    run(1);
    en = 1'b1;
    run(60);

    // en low together with resync: en wins.
    en = 1'b0; resync = 1'b1;
    cycle();
    resync = 1'b0;
    run(2);
    en = 1'b1;
    run(50);

    // Randomized traffic.
    for (int r = 0; r < 25; r++) begin
      div_int  = DIV_W'($urandom_range(2, 7));
      div_frac = FRAC_W'($urandom_range(0, 15));
      en = 1'b0;
      run(1);
      en = 1'b1;
      len = int'($urandom_range(50, 400));
      for (int k = 0; k < len; k++) begin
        p = int'($urandom_range(0, 199));
        if (p < 4) div_int = DIV_W'($urandom_range(1, 9));
        else if (p < 7) div_frac = FRAC_W'($urandom_range(0, 15));
        resync = (p == 10 || p == 11);
        en = (p != 12);
        cycle();
      end
      resync = 1'b0;
    end

    en = 1'b0;
    run(5);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
